cci_mem_responder: RTL and testbench
====================================

Name: cci_mem_responder

Overview:
- Host-side CCI responder model. It accepts AFU read requests on TX channel 0 and write requests on TX channel 1.
- It services both from an internal cache-line memory and returns in-order responses on RX channel 0 (read data) and RX channel 1 (write completions) after a programmable latency.
- Sits inside the emulator, facing the AFU TX/RX ports. Drives the almost-full flow control.

Parameters:
- MEM_AW, 6, cache-line index width; memory holds 2**MEM_AW lines of 512 bits; index = request address [MEM_AW-1:0].
- QDEPTH, 8, entries in each of the read and write response queues (power of 2).
- AF_MARGIN, 2, almost-full asserted when queue count >= QDEPTH-AF_MARGIN.
- RD_LAT, 8, minimum cycles from read accept to rx_c0_rdvalid (>=2).
- WR_LAT, 4, minimum cycles from write accept to rx_c1_wrvalid (>=2).

Ports:
- clk_32ui  in  1  clock
- sys_reset  in  1  reset; asynchronous, active-high
- tx_c0_header  in  61  read request header: [55:52] type, [45:14] line address, [13:0] mdata
- tx_c0_rdvalid  in  1  read request valid
- tx_c0_almostfull  out  1  read queue almost full
- tx_c1_header  in  61  write request header, same field layout
- tx_c1_data  in  512  write data
- tx_c1_wrvalid  in  1  write request valid
- tx_c1_almostfull  out  1  write queue almost full
- rx_c0_header  out  18  [17:14] response type 4'h4, [13:0] mdata
- rx_c0_data  out  512  read data
- rx_c0_rdvalid  out  1  read response valid, 1-cycle pulse per response
- rx_c1_header  out  18  [17:14] response type 4'h1, [13:0] mdata
- rx_c1_wrvalid  out  1  write response valid, 1-cycle pulse per response
- proto_err  out  1  sticky error flag

Behaviour:
- Reset: all outputs 0. Queues emptied. Timestamp counter = 0. Memory contents not reset.
- Timestamp: 16-bit free-running counter `now`, incremented every cycle. It wraps.
  - Age = now - entry_ts, computed modulo 2**16.
- Read accept:
  - tx_c0_rdvalid=1 with type 4'h4 and queue not full pushes {mdata, index, now}.
  - Any other type: request dropped, proto_err set.
- Write accept:
  - tx_c1_wrvalid=1 with type 4'h2 and queue not full writes tx_c1_data to mem[index] at that clock edge.
  - It also pushes {mdata, now} into the write queue.
  - Any other type: dropped, proto_err set, memory unchanged.
- Overflow: a push while the queue is full is dropped and sets proto_err. The queue count is unchanged.
- proto_err clears only on reset.
- Read response:
  - When the read queue is non-empty and head age >= RD_LAT, pop the head.
  - Next cycle: drive rx_c0_rdvalid=1, rx_c0_header={4'h4, mdata}, rx_c0_data=mem[index] sampled at the pop edge.
  - At most one pop per cycle. Responses are strictly in accept order.
- Write response: same rule with WR_LAT; drives rx_c1_wrvalid=1, rx_c1_header={4'h1, mdata}.
- Read/write ordering:
  - A read popped in the same cycle a write to the same index is accepted returns the old data.
  - A read popped on any later cycle returns the new data.
- Simultaneous push and pop on one queue in the same cycle: both occur, count unchanged. Legal when full, because the pop frees a slot first.
- Almost full: tx_cN_almostfull is registered. It equals (count >= QDEPTH-AF_MARGIN), evaluated on post-update count.
- When outputs are not valid, rx headers and data hold their last values. Verification must not check them unless valid is asserted.
- Reset asserted mid-operation: in-flight requests discarded, no response issued, all outputs 0 asynchronously.

Optional Feature:
- CCI_RSP_RANDLAT_EN
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - On each accept, lfsr[2:0] is added to the stored timestamp, so the effective latency becomes LAT+0..7 cycles.
  - A head entry blocks younger entries, so order is preserved.
- Undefined: latency is exactly LAT when the queue is uncongested. No LFSR logic is present.

Test Plan:
- Single read: write line 3 = 512'h...DEAD_BEEF with mdata 14'h0011, then 10 cycles later read addr 3 with mdata 14'h0022. Expect rx_c1_wrvalid with hdr 18'h04011 5 cycles after the write. Expect rx_c0_rdvalid with hdr 18'h10022 and data DEAD_BEEF exactly 9 cycles after the read accept.
- Back-to-back reads: 6 reads (mdata 1..6) on consecutive cycles. Expect tx_c0_almostfull=1 from the cycle after the 6th accept. Expect 6 consecutive rx_c0_rdvalid pulses in mdata order 1..6. Expect almostfull to drop after the 1st pop.
- Overflow: 9 reads with no drain possible (RD_LAT=40). Expect 8 accepted, proto_err=1, exactly 8 responses.
- Same-cycle hazard: read to index 5 pops in the same cycle as a write of 512'h1 to index 5 is accepted (old value 0). Expect read data 0. A following read returns 1.
- Bad type: tx_c0_rdvalid with type 4'h2. Expect no response and proto_err=1. Assert sys_reset mid-stream: all outputs 0 immediately, no stale responses after release.
- With CCI_RSP_RANDLAT_EN: 100 random reads. Check every latency is in [RD_LAT, RD_LAT+7] when uncongested and that order is preserved.

Source files
------------

// File: rtl/cci_mem_responder.sv
// cci_mem_responder: host-side CCI responder model with a cache-line memory and in-order read/write response queues.
// Latency: read data RD_LAT+1 cycles and write completion WR_LAT+1 cycles after the request cycle (more if the queue is congested).
// Backpressure: registered almost-full per channel; requests arriving on a full queue are dropped and flagged in sticky proto_err.
// Optional build macro CCI_RSP_RANDLAT_EN: adds 0..7 cycles of LFSR jitter to each accepted request.
module cci_mem_responder #(
  parameter int MEM_AW    = 6,
  parameter int QDEPTH    = 8,
  parameter int AF_MARGIN = 2,
  parameter int RD_LAT    = 8,
  parameter int WR_LAT    = 4
) (
  input  logic          clk_32ui,
  input  logic          sys_reset,
  input  logic [60:0]   tx_c0_header,
  input  logic          tx_c0_rdvalid,
  output logic          tx_c0_almostfull,
  input  logic [60:0]   tx_c1_header,
  input  logic [511:0]  tx_c1_data,
  input  logic          tx_c1_wrvalid,
  output logic          tx_c1_almostfull,
  output logic [17:0]   rx_c0_header,
  output logic [511:0]  rx_c0_data,
  output logic          rx_c0_rdvalid,
  output logic [17:0]   rx_c1_header,
  output logic          rx_c1_wrvalid,
  output logic          proto_err
);
  localparam int QAW = $clog2(QDEPTH);
  localparam int CW  = QAW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(QDEPTH);
  localparam logic [CW-1:0] C_AF   = CW'(QDEPTH - AF_MARGIN);

  typedef struct packed {
    logic [13:0]       mdata;
    logic [MEM_AW-1:0] idx;
    logic [15:0]       ts;
  } rd_ent_t;

  typedef struct packed {
    logic [13:0] mdata;
    logic [15:0] ts;
  } wr_ent_t;

  logic [511:0]   r_mem [0:(1<<MEM_AW)-1];
  rd_ent_t        r_rdq [0:QDEPTH-1];
  wr_ent_t        r_wrq [0:QDEPTH-1];
  logic [QAW-1:0] r_rd_wp, r_rd_rp, r_wr_wp, r_wr_rp;
  logic [CW-1:0]  r_rd_cnt, r_wr_cnt;
  logic [15:0]    r_now;

  logic [15:0]    w_ts_in;
  rd_ent_t        w_rd_head;
  wr_ent_t        w_wr_head;
  logic [15:0]    w_rd_age, w_wr_age;
  logic           w_rd_req, w_wr_req, w_rd_bad, w_wr_bad;
  logic           w_rd_pop, w_wr_pop, w_rd_push, w_wr_push;
  logic [CW-1:0]  w_rd_cnt_nxt, w_wr_cnt_nxt;
  logic           w_unused;

`ifdef CCI_RSP_RANDLAT_EN
  logic [15:0] r_lfsr;

  // Fibonacci LFSR (taps 16,14,13,11) supplying per-request latency jitter
  always_ff @(posedge clk_32ui or posedge sys_reset) begin
    if (sys_reset) r_lfsr <= 16'hACE1;
    else           r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  // Jittered timestamps can sit in the future; a negative age must not count as ripe
  function automatic logic f_ripe(input logic [15:0] age, input int lat);
    return !age[15] && (age >= 16'(lat));
  endfunction

  assign w_ts_in = r_now + {13'd0, r_lfsr[2:0]};
`else
  function automatic logic f_ripe(input logic [15:0] age, input int lat);
    return age >= 16'(lat);
  endfunction

  assign w_ts_in = r_now;
`endif

  assign w_unused = ^{tx_c0_header[60:56], tx_c0_header[51:14+MEM_AW],
                      tx_c1_header[60:56], tx_c1_header[51:14+MEM_AW]};

  assign w_rd_head = r_rdq[r_rd_rp];
  assign w_wr_head = r_wrq[r_wr_rp];
  assign w_rd_age  = r_now - w_rd_head.ts;
  assign w_wr_age  = r_now - w_wr_head.ts;

  assign w_rd_req  = tx_c0_rdvalid && (tx_c0_header[55:52] == 4'h4);
  assign w_wr_req  = tx_c1_wrvalid && (tx_c1_header[55:52] == 4'h2);
  assign w_rd_bad  = tx_c0_rdvalid && (tx_c0_header[55:52] != 4'h4);
  assign w_wr_bad  = tx_c1_wrvalid && (tx_c1_header[55:52] != 4'h2);

  assign w_rd_pop  = (r_rd_cnt != '0) && f_ripe(w_rd_age, RD_LAT);
  assign w_wr_pop  = (r_wr_cnt != '0) && f_ripe(w_wr_age, WR_LAT);
  // A pop in the same cycle frees a slot, so a push onto a full queue is still legal then
  assign w_rd_push = w_rd_req && ((r_rd_cnt != C_FULL) || w_rd_pop);
  assign w_wr_push = w_wr_req && ((r_wr_cnt != C_FULL) || w_wr_pop);

  assign w_rd_cnt_nxt = r_rd_cnt + CW'(w_rd_push) - CW'(w_rd_pop);
  assign w_wr_cnt_nxt = r_wr_cnt + CW'(w_wr_push) - CW'(w_wr_pop);

  // Cache-line memory and queue payload storage; contents survive reset
  always_ff @(posedge clk_32ui) begin
    if (w_wr_push) r_mem[tx_c1_header[14 +: MEM_AW]] <= tx_c1_data;
    if (w_rd_push) r_rdq[r_rd_wp] <= '{mdata: tx_c0_header[13:0], idx: tx_c0_header[14 +: MEM_AW], ts: w_ts_in};
    if (w_wr_push) r_wrq[r_wr_wp] <= '{mdata: tx_c1_header[13:0], ts: w_ts_in};
  end

  // Timestamp, queue pointers/counts, almost-full flags and sticky error
  always_ff @(posedge clk_32ui or posedge sys_reset) begin
    if (sys_reset) begin
      r_now            <= '0;
      r_rd_wp          <= '0;
      r_rd_rp          <= '0;
      r_wr_wp          <= '0;
      r_wr_rp          <= '0;
      r_rd_cnt         <= '0;
      r_wr_cnt         <= '0;
      tx_c0_almostfull <= 1'b0;
      tx_c1_almostfull <= 1'b0;
      proto_err        <= 1'b0;
    end else begin
      r_now            <= r_now + 16'd1;
      if (w_rd_push) r_rd_wp <= r_rd_wp + QAW'(1);
      if (w_rd_pop)  r_rd_rp <= r_rd_rp + QAW'(1);
      if (w_wr_push) r_wr_wp <= r_wr_wp + QAW'(1);
      if (w_wr_pop)  r_wr_rp <= r_wr_rp + QAW'(1);
      r_rd_cnt         <= w_rd_cnt_nxt;
      r_wr_cnt         <= w_wr_cnt_nxt;
      tx_c0_almostfull <= (w_rd_cnt_nxt >= C_AF);
      tx_c1_almostfull <= (w_wr_cnt_nxt >= C_AF);
      proto_err        <= proto_err | w_rd_bad | w_wr_bad
                          | (w_rd_req && !w_rd_push) | (w_wr_req && !w_wr_push);
    end
  end

  // Response outputs; memory is read at the pop edge so a same-edge write is not seen
  always_ff @(posedge clk_32ui or posedge sys_reset) begin
    if (sys_reset) begin
      rx_c0_rdvalid <= 1'b0;
      rx_c0_header  <= '0;
      rx_c0_data    <= '0;
      rx_c1_wrvalid <= 1'b0;
      rx_c1_header  <= '0;
    end else begin
      rx_c0_rdvalid <= w_rd_pop;
      rx_c1_wrvalid <= w_wr_pop;
      if (w_rd_pop) begin
        rx_c0_header <= {4'h4, w_rd_head.mdata};
        rx_c0_data   <= r_mem[w_rd_head.idx];
      end
      if (w_wr_pop) rx_c1_header <= {4'h1, w_wr_head.mdata};
    end
  end

endmodule

// File: tb/tb_cci_mem_responder.sv
// tb_cci_mem_responder: scoreboard bench for cci_mem_responder (main instance plus a long-latency instance for overflow).
// Latency: expected response cycle windows are pushed at issue time and checked by negedge monitors.
// Backpressure: almost-full and proto_err are checked directly by the stimulus process.
module tb_cci_mem_responder;
  localparam int RD_LAT  = 8;
  localparam int WR_LAT  = 4;
  localparam int RD_LAT2 = 40;
`ifdef CCI_RSP_RANDLAT_EN
  localparam int JIT = 7;
`else
  localparam int JIT = 0;
`endif

  typedef struct {
    logic [17:0]  hdr;
    logic [511:0] data;
    bit           chk;
    int           lo;
    int           hi;
  } exp_t;

  logic         clk = 1'b0;
  logic         sys_reset = 1'b1;
  logic [60:0]  tx_c0_header = '0;
  logic         tx_c0_rdvalid = 1'b0;
  logic [60:0]  tx_c1_header = '0;
  logic [511:0] tx_c1_data = '0;
  logic         tx_c1_wrvalid = 1'b0;
  logic         tx_c0_almostfull, tx_c1_almostfull, rx_c0_rdvalid, rx_c1_wrvalid, proto_err;
  logic [17:0]  rx_c0_header, rx_c1_header;
  logic [511:0] rx_c0_data;

  logic [60:0]  t2_c0_header = '0;
  logic         t2_c0_rdvalid = 1'b0;
  logic [60:0]  t2_c1_header = '0;
  logic [511:0] t2_c1_data = '0;
  logic         t2_c1_wrvalid = 1'b0;
  logic         t2_c0_af, t2_c1_af, r2_c0_vld, r2_c1_vld, t2_err;
  logic [17:0]  r2_c0_hdr, r2_c1_hdr;
  logic [511:0] r2_c0_dat;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   r2_cnt = 0;
  exp_t q_rd[$];
  exp_t q_wr[$];
  exp_t q2[$];

  cci_mem_responder #(.MEM_AW(6), .QDEPTH(8), .AF_MARGIN(2), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) u_dut (
    .clk_32ui(clk), .sys_reset(sys_reset),
    .tx_c0_header(tx_c0_header), .tx_c0_rdvalid(tx_c0_rdvalid), .tx_c0_almostfull(tx_c0_almostfull),
    .tx_c1_header(tx_c1_header), .tx_c1_data(tx_c1_data), .tx_c1_wrvalid(tx_c1_wrvalid),
    .tx_c1_almostfull(tx_c1_almostfull),
    .rx_c0_header(rx_c0_header), .rx_c0_data(rx_c0_data), .rx_c0_rdvalid(rx_c0_rdvalid),
    .rx_c1_header(rx_c1_header), .rx_c1_wrvalid(rx_c1_wrvalid), .proto_err(proto_err)
  );

  cci_mem_responder #(.MEM_AW(6), .QDEPTH(8), .AF_MARGIN(2), .RD_LAT(RD_LAT2), .WR_LAT(WR_LAT)) u_dut2 (
    .clk_32ui(clk), .sys_reset(sys_reset),
    .tx_c0_header(t2_c0_header), .tx_c0_rdvalid(t2_c0_rdvalid), .tx_c0_almostfull(t2_c0_af),
    .tx_c1_header(t2_c1_header), .tx_c1_data(t2_c1_data), .tx_c1_wrvalid(t2_c1_wrvalid),
    .tx_c1_almostfull(t2_c1_af),
    .rx_c0_header(r2_c0_hdr), .rx_c0_data(r2_c0_dat), .rx_c0_rdvalid(r2_c0_vld),
    .rx_c1_header(r2_c1_hdr), .rx_c1_wrvalid(r2_c1_vld), .proto_err(t2_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_rng(input string name, input int v, input int lo, input int hi);
    n_tests++;
    if (v < lo || v > hi) begin
      n_fail++;
      $display("FAIL %s: got cycle %0d, required %0d..%0d", name, v, lo, hi);
    end
  endtask

  task automatic unexpected(input string name, input logic [17:0] hdr);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected response hdr %0h at cycle %0d", name, hdr, cyc);
  endtask

  function automatic logic [60:0] mk_hdr(input logic [3:0] t, input logic [31:0] a, input logic [13:0] m);
    logic [60:0] h;
    h = '0;
    h[55:52] = t;
    h[45:14] = a;
    h[13:0]  = m;
    return h;
  endfunction

  // Drive one read/write on the main instance for the current cycle; expectations are pushed separately
  task automatic drive_rd(input logic [3:0] t, input logic [31:0] a, input logic [13:0] m);
    tx_c0_rdvalid = 1'b1;
    tx_c0_header  = mk_hdr(t, a, m);
  endtask

  task automatic drive_wr(input logic [3:0] t, input logic [31:0] a, input logic [13:0] m, input logic [511:0] d);
    tx_c1_wrvalid = 1'b1;
    tx_c1_header  = mk_hdr(t, a, m);
    tx_c1_data    = d;
  endtask

  task automatic rd(input logic [31:0] a, input logic [13:0] m, input logic [511:0] d);
    exp_t e;
    drive_rd(4'h4, a, m);
    e.hdr = {4'h4, m}; e.data = d; e.chk = 1'b1;
    e.lo = cyc + RD_LAT + 1; e.hi = e.lo + JIT;
    q_rd.push_back(e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [13:0] m, input logic [511:0] d);
    exp_t e;
    drive_wr(4'h2, a, m, d);
    e.hdr = {4'h1, m}; e.data = '0; e.chk = 1'b0;
    e.lo = cyc + WR_LAT + 1; e.hi = e.lo + JIT;
    q_wr.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    tx_c0_rdvalid = 1'b0;
    tx_c1_wrvalid = 1'b0;
    t2_c0_rdvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_rd.size() != 0 || q_wr.size() != 0 || q2.size() != 0) && n < 300) begin
      step();
      n++;
    end
    check("drain_pending", 512'(q_rd.size() + q_wr.size() + q2.size()), '0);
  endtask

  // Read-response monitor for the main instance
  always @(negedge clk) begin
    if (rx_c0_rdvalid) begin
      if (q_rd.size() == 0) unexpected("rd_resp", rx_c0_header);
      else begin
        exp_t e;
        e = q_rd.pop_front();
        check("rd_hdr", 512'(rx_c0_header), 512'(e.hdr));
        if (e.chk) check("rd_data", rx_c0_data, e.data);
        check_rng("rd_cycle", cyc, e.lo, e.hi);
      end
    end
  end

  // Write-completion monitor for the main instance
  always @(negedge clk) begin
    if (rx_c1_wrvalid) begin
      if (q_wr.size() == 0) unexpected("wr_resp", rx_c1_header);
      else begin
        exp_t e;
        e = q_wr.pop_front();
        check("wr_hdr", 512'(rx_c1_header), 512'(e.hdr));
        check_rng("wr_cycle", cyc, e.lo, e.hi);
      end
    end
  end

  // Read-response monitor for the long-latency instance
  always @(negedge clk) begin
    if (r2_c0_vld) begin
      r2_cnt++;
      if (q2.size() == 0) unexpected("ovf_resp", r2_c0_hdr);
      else begin
        exp_t e;
        e = q2.pop_front();
        check("ovf_hdr", 512'(r2_c0_hdr), 512'(e.hdr));
        check_rng("ovf_cycle", cyc, e.lo, e.hi);
      end
    end
  end

  initial begin
    int k;
    exp_t e;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_c0_af", 512'(tx_c0_almostfull), '0);
    check("rst_c1_af", 512'(tx_c1_almostfull), '0);
    check("rst_rdvalid", 512'(rx_c0_rdvalid), '0);
    check("rst_wrvalid", 512'(rx_c1_wrvalid), '0);
    check("rst_err", 512'(proto_err), '0);
    check("rst_c0_hdr", 512'(rx_c0_header), '0);
    check("rst_c0_data", rx_c0_data, '0);
    sys_reset = 1'b0;
    step();

    // Single write then read of line 3
    wr(3, 14'h0011, 512'hDEAD_BEEF);
    step();
    repeat (9) step();
    rd(3, 14'h0022, 512'hDEAD_BEEF);
    step();
    drain();

    // Back-to-back reads and almost-full
    for (int i = 1; i <= 6; i++) begin
      rd(3, 14'(i), 512'hDEAD_BEEF);
      step();
      check($sformatf("af_after_accept%0d", i), 512'(tx_c0_almostfull), 512'(i >= 6));
    end
`ifndef CCI_RSP_RANDLAT_EN
    repeat (2) step();
    check("af_before_pop", 512'(tx_c0_almostfull), 512'd1);
    step();
    check("af_after_pop", 512'(tx_c0_almostfull), '0);
`endif
    drain();
    check("af_drained", 512'(tx_c0_almostfull), '0);

`ifndef CCI_RSP_RANDLAT_EN
    // Same-edge hazard: read of line 5 pops while a write of 1 to line 5 is accepted
    wr(5, 14'h0050, '0);
    step();
    repeat (10) step();
    rd(5, 14'h0051, '0);
    step();
    repeat (7) step();
    wr(5, 14'h0052, 512'h1);
    step();
    rd(5, 14'h0053, 512'h1);
    step();
    drain();
`endif
    check("err_clean", 512'(proto_err), '0);

    // Bad request types: no response, sticky error, memory unchanged
    drive_rd(4'h2, 3, 14'h0033);
    step();
    check("err_bad_rd", 512'(proto_err), 512'd1);
    drive_wr(4'h4, 3, 14'h0034, 512'h1234);
    step();
    repeat (15) step();
    check("err_sticky", 512'(proto_err), 512'd1);
    rd(3, 14'h0035, 512'hDEAD_BEEF);
    step();
    drain();

    // Overflow on the long-latency instance: 9 reads, 8 accepted
    for (int i = 1; i <= 9; i++) begin
      t2_c0_rdvalid = 1'b1;
      t2_c0_header  = mk_hdr(4'h4, 7, 14'(12'h070 + i));
      if (i <= 8) begin
        e.hdr = {4'h4, 14'(12'h070 + i)}; e.data = '0; e.chk = 1'b0;
        e.lo = cyc + RD_LAT2 + 1; e.hi = e.lo + JIT;
        q2.push_back(e);
      end
      step();
      check($sformatf("ovf_err_after%0d", i), 512'(t2_err), 512'(i == 9));
    end
    drain();
    repeat (10) step();
    check("ovf_resp_count", 512'(r2_cnt), 512'd8);

    // Reset mid-stream: three reads in flight, reset while the first response is visible
    k = cyc;
    for (int i = 0; i < 3; i++) begin
      drive_rd(4'h4, 3, 14'(12'h061 + i));
      step();
    end
    while (cyc < k + RD_LAT + 1) step();
`ifndef CCI_RSP_RANDLAT_EN
    check("pre_rst_rdvalid", 512'(rx_c0_rdvalid), 512'd1);
`endif
    sys_reset = 1'b1;
    #1;
    check("arst_rdvalid", 512'(rx_c0_rdvalid), '0);
    check("arst_c0_hdr", 512'(rx_c0_header), '0);
    check("arst_c0_data", rx_c0_data, '0);
    check("arst_err", 512'(proto_err), '0);
    check("arst_err2", 512'(t2_err), '0);
    check("arst_c0_af", 512'(tx_c0_almostfull), '0);
    step();
    step();
    sys_reset = 1'b0;
    repeat (25) step();
    check("post_rst_rdvalid", 512'(rx_c0_rdvalid), '0);
    rd(3, 14'h0070, 512'hDEAD_BEEF);
    step();
    drain();

`ifdef CCI_RSP_RANDLAT_EN
    // Random latency: spaced reads, each within LAT..LAT+7 and in order
    for (int i = 0; i < 100; i++) begin
      rd(3, 14'(12'h100 + i), 512'hDEAD_BEEF);
      step();
      repeat (9) step();
    end
    drain();
`endif

    check("final_pending", 512'(q_rd.size() + q_wr.size() + q2.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
